game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
- Top-level sequencer for the code-breaking game.
- Generates and latches the secret code, and drives the guess-history block's mode, select and reset controls.
- Runs a request/valid handshake with the scorer, counts turns, and decides win/loss.
- Sits between the debounced button pulses and the history/scorer/display datapath.

Parameters:
- MAX_TURNS, 8, number of guesses per game; turn counter width is 3 bits, so MAX_TURNS ≤ 8.
- SCORE_TIMEOUT, 15, maximum cycles to wait for score_valid after score_req rises.
- LFSR_SEED, 12'hACE, non-zero reset value of the secret-code LFSR.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- btn_start  in  1  one-cycle debounced pulse: begin a new game.
- btn_select  in  1  one-cycle pulse: commit the current guess.
- btn_mode  in  1  one-cycle pulse: toggle guess/history view.
- score_exact  in  3  scorer result, correct colour and position (0..4).
- score_partial  in  3  scorer result, correct colour, wrong position (0..4).
- score_valid  in  1  scorer result valid, one cycle.
- secret3..secret0  out  3 each  latched secret code digits.
- hist_mode  out  1  0 = guess view, 1 = history view (history block's mode).
- hist_select  out  1  one-cycle store strobe to the history block.
- hist_reset  out  1  one-cycle clear strobe to the history block.
- score_req  out  1  level request to the scorer.
- turn  out  3  index of the current turn, 0..MAX_TURNS-1.
- exact_last, partial_last  out  3 each  latched score of the most recent guess.
- game_won, game_lost, score_err  out  1 each  status flags.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and the LFSR loads LFSR_SEED.
  - Every output is 0, including secrets, turn, all flags and all strobes.
- LFSR:
  - 12-bit Fibonacci, taps 12,11,10,4; shifts every clk, in every state.
  - secret3..0 = lfsr[11:9], [8:6], [5:3], [2:0], sampled on the cycle btn_start is seen.
- btn_start, in any state:
  - Next cycle: latch the secret, hist_reset=1 for exactly one cycle.
  - Clear turn, exact_last, partial_last, game_won, game_lost and score_err; hist_mode=0; state goes to GUESS.
  - btn_start has priority over every other input in the same cycle.
  - btn_start during SCORE abandons the request: score_req drops the next cycle.
- IDLE: ignores btn_select and btn_mode.
- GUESS:
  - btn_select → hist_select=1 for one cycle, score_req=1 from the next cycle, state goes to SCORE.
  - btn_mode → hist_mode=1, state goes to HISTORY.
  - btn_select and btn_mode in the same cycle: btn_select wins and btn_mode is dropped.
- SCORE:
  - score_req is held high and a wait counter runs.
  - On score_valid: latch exact_last and partial_last, drop score_req the next cycle, then:
    - exact==4 → WIN, game_won=1;
    - else turn==MAX_TURNS-1 → LOSE, game_lost=1;
    - else turn+1 and return to GUESS.
  - If the wait counter reaches SCORE_TIMEOUT with no valid: score_err=1 (sticky until btn_start), drop score_req, return to GUESS, turn unchanged.
  - btn_select and btn_mode are ignored in SCORE.
- HISTORY:
  - btn_mode → hist_mode=0, state goes to GUESS.
  - btn_select ignored; the history block handles up/down itself.
- WIN / LOSE:
  - Terminal until btn_start.
  - btn_mode toggles hist_mode for review.
  - btn_select never produces hist_select.
- turn never exceeds MAX_TURNS-1; there is no wrap-around.
- Score inputs with exact>4 or exact+partial>4 are treated as a scorer fault: score_err=1, handled as a timeout.

Decomposition:
- Package game_pkg holds:
  - the state enum IDLE/GUESS/SCORE/HISTORY/WIN/LOSE;
  - DIGIT_W=3, NUM_DIGITS=4, WIN_EXACT=4;
  - the LFSR tap constant.
- One sub-module, code_lfsr: 12-bit LFSR with seed parameter and async active-low reset.
- The FSM, turn counter and timeout counter stay in game_controller.

Test Plan:
- Reset release then btn_start → one hist_reset pulse next cycle; secret = first LFSR value after the seed; turn=0; state GUESS.
- btn_select, then score_valid 3 cycles later with exact=1, partial=2 → exactly one hist_select pulse; score_req high for 3 cycles; exact_last=1, partial_last=2; turn=1.
- Eight scored guesses with exact<4 → game_lost=1 after the 8th valid; turn stays 7; further btn_select gives no hist_select.
- Guess scored exact=4 on turn 2 → game_won=1, state WIN; btn_mode toggles hist_mode 1→0; btn_start restarts with flags cleared.
- No score_valid for 15 cycles after request → score_err=1, score_req=0, state GUESS, turn unchanged.
- btn_select and btn_mode in the same GUESS cycle → SCORE with hist_mode=0. Async reset asserted mid-SCORE → all outputs 0 immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Purpose: shared types and constants for the code-breaking game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  localparam int DIGIT_W    = 3;
  localparam int NUM_DIGITS = 4;
  localparam int LFSR_W     = DIGIT_W * NUM_DIGITS;
  localparam int TURN_W     = 3;

  localparam logic [DIGIT_W-1:0] WIN_EXACT = 3'd4;

  // Fibonacci taps 12,11,10,4 expressed as bit positions 11,10,9,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'hE08;

  typedef enum logic [2:0] {
    IDLE,
    GUESS,
    SCORE,
    HISTORY,
    WIN,
    LOSE
  } state_t;

  // A result claiming more than four pegs in total cannot come from a
  // healthy scorer.
  function automatic logic score_bad(input logic [DIGIT_W-1:0] exact,
                                     input logic [DIGIT_W-1:0] partial);
    logic [DIGIT_W:0] sum;
    sum = {1'b0, exact} + {1'b0, partial};
    return (exact > WIN_EXACT) || (sum > {1'b0, WIN_EXACT});
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Purpose: scorer request/valid handshake plus history-block controls.
// Latency: n/a (wires only).
// Backpressure: none; the scorer answers a held request with a one-cycle valid.
// master = controller side, slave = scorer/history datapath side.
interface game_controller_if;
  import game_pkg::*;

  logic               score_req;
  logic               score_valid;
  logic [DIGIT_W-1:0] score_exact;
  logic [DIGIT_W-1:0] score_partial;
  logic               hist_mode;
  logic               hist_select;
  logic               hist_reset;

  modport master (
    output score_req, hist_mode, hist_select, hist_reset,
    input  score_valid, score_exact, score_partial
  );

  modport slave (
    input  score_req, hist_mode, hist_select, hist_reset,
    output score_valid, score_exact, score_partial
  );

endinterface

// File: rtl/code_lfsr.sv
// Purpose: free-running 12-bit Fibonacci LFSR used as the secret-code source.
// Latency: new value every clk edge.
// Backpressure: none; never stalls.
// Ports: clk, reset (async active-low, loads SEED), lfsr (current state).
module code_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 12'hACE
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr
);

  logic feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/game_controller.sv
// Purpose: game sequencer: secret latch, history strobes, scorer handshake, turn/win/loss.
// Latency: every output is registered, one cycle after the button/valid that causes it.
// Backpressure: score_req held until score_valid or SCORE_TIMEOUT cycles; buttons never stall.
// Ports: clk, reset (async active-low), btn_start/btn_select/btn_mode pulses,
//        bus (scorer + history controls), secret3..0, turn, exact_last,
//        partial_last, game_won, game_lost, score_err.
module game_controller
  import game_pkg::*;
#(
  parameter int                MAX_TURNS     = 8,
  parameter int                SCORE_TIMEOUT = 15,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 12'hACE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_start,
  input  logic                btn_select,
  input  logic                btn_mode,
  game_controller_if.master   bus,
  output logic [DIGIT_W-1:0]  secret3,
  output logic [DIGIT_W-1:0]  secret2,
  output logic [DIGIT_W-1:0]  secret1,
  output logic [DIGIT_W-1:0]  secret0,
  output logic [TURN_W-1:0]   turn,
  output logic [DIGIT_W-1:0]  exact_last,
  output logic [DIGIT_W-1:0]  partial_last,
  output logic                game_won,
  output logic                game_lost,
  output logic                score_err
);

  localparam int                WAIT_W    = $clog2(SCORE_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SCORE_TIMEOUT - 1);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(MAX_TURNS - 1);

  logic [LFSR_W-1:0]  lfsr;
  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  secret_q, secret_d;
  logic [TURN_W-1:0]  turn_d;
  logic [DIGIT_W-1:0] exact_d, partial_d;
  logic               won_d, lost_d, err_d;
  logic               mode_q, mode_d;
  logic               sel_q, sel_d;
  logic               clr_q, clr_d;
  logic               req_q, req_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  code_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign secret3 = secret_q[3*DIGIT_W +: DIGIT_W];
  assign secret2 = secret_q[2*DIGIT_W +: DIGIT_W];
  assign secret1 = secret_q[1*DIGIT_W +: DIGIT_W];
  assign secret0 = secret_q[0*DIGIT_W +: DIGIT_W];

  assign bus.score_req   = req_q;
  assign bus.hist_mode   = mode_q;
  assign bus.hist_select = sel_q;
  assign bus.hist_reset  = clr_q;

  always_comb begin
    state_d   = state_q;
    secret_d  = secret_q;
    turn_d    = turn;
    exact_d   = exact_last;
    partial_d = partial_last;
    won_d     = game_won;
    lost_d    = game_lost;
    err_d     = score_err;
    mode_d    = mode_q;
    req_d     = req_q;
    wait_d    = wait_q;
    sel_d     = 1'b0;
    clr_d     = 1'b0;

    // Start overrides everything, including an outstanding score request.
    if (btn_start) begin
      state_d   = GUESS;
      secret_d  = lfsr;
      clr_d     = 1'b1;
      turn_d    = '0;
      exact_d   = '0;
      partial_d = '0;
      won_d     = 1'b0;
      lost_d    = 1'b0;
      err_d     = 1'b0;
      mode_d    = 1'b0;
      req_d     = 1'b0;
      wait_d    = '0;
    end else begin
      case (state_q)
        IDLE: ;
        GUESS: begin
          // Select wins over a simultaneous mode press.
          if (btn_select) begin
            sel_d   = 1'b1;
            req_d   = 1'b1;
            wait_d  = '0;
            state_d = SCORE;
          end else if (btn_mode) begin
            mode_d  = 1'b1;
            state_d = HISTORY;
          end
        end
        SCORE: begin
          if (bus.score_valid) begin
            req_d = 1'b0;
            if (score_bad(bus.score_exact, bus.score_partial)) begin
              err_d   = 1'b1;
              state_d = GUESS;
            end else begin
              exact_d   = bus.score_exact;
              partial_d = bus.score_partial;
              if (bus.score_exact == WIN_EXACT) begin
                won_d   = 1'b1;
                state_d = WIN;
              end else if (turn == LAST_TURN) begin
                lost_d  = 1'b1;
                state_d = LOSE;
              end else begin
                turn_d  = turn + TURN_W'(1);
                state_d = GUESS;
              end
            end
          end else if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = GUESS;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        HISTORY: begin
          if (btn_mode) begin
            mode_d  = 1'b0;
            state_d = GUESS;
          end
        end
        WIN, LOSE: begin
          if (btn_mode) mode_d = ~mode_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      secret_q     <= '0;
      turn         <= '0;
      exact_last   <= '0;
      partial_last <= '0;
      game_won     <= 1'b0;
      game_lost    <= 1'b0;
      score_err    <= 1'b0;
      mode_q       <= 1'b0;
      sel_q        <= 1'b0;
      clr_q        <= 1'b0;
      req_q        <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      secret_q     <= secret_d;
      turn         <= turn_d;
      exact_last   <= exact_d;
      partial_last <= partial_d;
      game_won     <= won_d;
      game_lost    <= lost_d;
      score_err    <= err_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      clr_q        <= clr_d;
      req_q        <= req_d;
      wait_q       <= wait_d;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Purpose: self-checking bench for game_controller (vector tables + directed corner cases).
// Latency: n/a.
// Backpressure: n/a; the bench plays the scorer and drives score_valid itself.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_select = 1'b0;
  logic       btn_mode = 1'b0;
  logic [2:0] secret3, secret2, secret1, secret0;
  logic [2:0] turn, exact_last, partial_last;
  logic       game_won, game_lost, score_err;

  game_controller_if bus();

  game_controller dut (
    .clk          (clk),
    .reset        (reset),
    .btn_start    (btn_start),
    .btn_select   (btn_select),
    .btn_mode     (btn_mode),
    .bus          (bus),
    .secret3      (secret3),
    .secret2      (secret2),
    .secret1      (secret1),
    .secret0      (secret0),
    .turn         (turn),
    .exact_last   (exact_last),
    .partial_last (partial_last),
    .game_won     (game_won),
    .game_lost    (game_lost),
    .score_err    (score_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;     // cycles from request to valid; 0 = never answer
    int exact;
    int partial;
    int exp_turn;
    int exp_won;
    int exp_lost;
    int exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int hr_cnt = 0;
  logic prev_req = 1'b0;
  logic [11:0] m_lfsr;
  logic [11:0] secret_q[$];
  logic [5:0]  score_q[$];
  vec_t tab_a[11];
  vec_t tab_b[3];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR: 12-bit Fibonacci, taps 12,11,10,4, seed 0xACE.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 12'hACE;
    else        m_lfsr <= {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[10] ^ m_lfsr[9] ^ m_lfsr[3]};
  end

  // Output monitor: strobe counting and scoreboard pops.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.hist_select) hs_cnt++;
      if (bus.hist_reset) begin
        hr_cnt++;
        if (secret_q.size() == 0) begin
          check("unexpected hist_reset", 1, 0);
        end else begin
          check("secret", int'({secret3, secret2, secret1, secret0}), int'(secret_q.pop_front()));
        end
      end
      if (prev_req && !bus.score_req && score_q.size() > 0) begin
        logic [5:0] e;
        e = score_q.pop_front();
        check("exact_last", int'(exact_last), int'(e[5:3]));
        check("partial_last", int'(partial_last), int'(e[2:0]));
      end
    end
    prev_req = bus.score_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({secret3, secret2, secret1, secret0, turn, exact_last, partial_last,
                 game_won, game_lost, score_err,
                 bus.hist_mode, bus.hist_select, bus.hist_reset, bus.score_req});
  endfunction

  task automatic press_start(input string tag);
    int hr0;
    hr0 = hr_cnt;
    btn_start = 1'b1;
    secret_q.push_back(m_lfsr);
    step();
    btn_start = 1'b0;
    check({tag, " hist_reset"}, bus.hist_reset, 1);
    step();
    check({tag, " hist_reset pulses"}, hr_cnt - hr0, 1);
    check({tag, " turn"}, turn, 0);
    check({tag, " flags"}, int'({game_won, game_lost, score_err}), 0);
    check({tag, " last score"}, int'({exact_last, partial_last}), 0);
    check({tag, " mode/req"}, int'({bus.hist_mode, bus.score_req}), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int hs0, req_cnt;
    hs0 = hs_cnt;
    req_cnt = 0;
    btn_select = 1'b1;
    step();
    btn_select = 1'b0;
    if (v.delay == 0) begin
      for (int c = 0; c < 20 && bus.score_req; c++) begin
        req_cnt++;
        step();
      end
      check({tag, " req cycles"}, req_cnt, 15);
    end else begin
      for (int c = 1; c < v.delay; c++) begin
        if (bus.score_req) req_cnt++;
        step();
      end
      if (bus.score_req) req_cnt++;
      bus.score_exact   = 3'(v.exact);
      bus.score_partial = 3'(v.partial);
      bus.score_valid   = 1'b1;
      if (!(v.exact > 4 || v.exact + v.partial > 4))
        score_q.push_back({3'(v.exact), 3'(v.partial)});
      step();
      bus.score_valid = 1'b0;
      check({tag, " req cycles"}, req_cnt, v.delay);
    end
    check({tag, " req dropped"}, bus.score_req, 0);
    check({tag, " hist_select pulses"}, hs_cnt - hs0, 1);
    check({tag, " turn"}, turn, v.exp_turn);
    check({tag, " won"}, game_won, v.exp_won);
    check({tag, " lost"}, game_lost, v.exp_lost);
    check({tag, " err"}, score_err, v.exp_err);
  endtask

  initial begin
    int hs0;
    bus.score_valid   = 1'b0;
    bus.score_exact   = 3'd0;
    bus.score_partial = 3'd0;

    //            delay ex pa turn won lost err
    tab_a[0]  = '{3, 1, 2, 1, 0, 0, 0};
    tab_a[1]  = '{1, 0, 0, 2, 0, 0, 0};
    tab_a[2]  = '{5, 2, 2, 3, 0, 0, 0};
    tab_a[3]  = '{0, 0, 0, 3, 0, 0, 1};   // timeout
    tab_a[4]  = '{2, 3, 0, 4, 0, 0, 1};
    tab_a[5]  = '{1, 0, 4, 5, 0, 0, 1};
    tab_a[6]  = '{4, 3, 1, 6, 0, 0, 1};
    tab_a[7]  = '{2, 1, 1, 7, 0, 0, 1};
    tab_a[8]  = '{1, 5, 0, 7, 0, 0, 1};   // exact>4 fault
    tab_a[9]  = '{1, 2, 3, 7, 0, 0, 1};   // sum>4 fault
    tab_a[10] = '{2, 0, 3, 7, 0, 1, 1};   // eighth scored guess
    tab_b[0]  = '{2, 0, 1, 1, 0, 0, 0};
    tab_b[1]  = '{1, 2, 0, 2, 0, 0, 0};
    tab_b[2]  = '{3, 4, 0, 2, 1, 0, 0};

    #12;
    check("reset outputs", all_outs(), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // First start after one shift: secret must be 0x59D = 2,6,3,5.
    press_start("start1");
    check("secret digits", int'({secret3, secret2, secret1, secret0}), int'({3'd2, 3'd6, 3'd3, 3'd5}));

    for (int i = 0; i < 11; i++) run_vec(tab_a[i], $sformatf("lose v%0d", i));

    // LOSE is terminal: select ignored, mode toggles.
    hs0 = hs_cnt;
    btn_select = 1'b1; step(); btn_select = 1'b0; step();
    check("lose select ignored", hs_cnt - hs0, 0);
    check("lose no req", bus.score_req, 0);
    check("lose turn held", turn, 7);
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("lose mode toggle", bus.hist_mode, 1);

    press_start("start2");
    for (int i = 0; i < 3; i++) run_vec(tab_b[i], $sformatf("win v%0d", i));
    hs0 = hs_cnt;
    btn_select = 1'b1; step(); btn_select = 1'b0; step();
    check("win select ignored", hs_cnt - hs0, 0);
    check("win no req", bus.score_req, 0);
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("win mode 0->1", bus.hist_mode, 1);
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("win mode 1->0", bus.hist_mode, 0);
    press_start("start3");

    // HISTORY view: select ignored, mode returns to GUESS.
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("history mode", bus.hist_mode, 1);
    hs0 = hs_cnt;
    btn_select = 1'b1; step(); btn_select = 1'b0; step();
    check("history select ignored", hs_cnt - hs0, 0);
    check("history no req", bus.score_req, 0);
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("history exit", bus.hist_mode, 0);

    // Select and mode together: select wins.
    hs0 = hs_cnt;
    btn_select = 1'b1; btn_mode = 1'b1; step(); btn_select = 1'b0; btn_mode = 1'b0;
    check("sel+mode hist_select", bus.hist_select, 1);
    check("sel+mode req", bus.score_req, 1);
    check("sel+mode hist_mode", bus.hist_mode, 0);
    step();
    check("sel+mode single pulse", hs_cnt - hs0, 1);

    // Start during SCORE abandons the request.
    press_start("start in score");

    // Async reset in the middle of SCORE.
    btn_select = 1'b1; step(); btn_select = 1'b0; step();
    check("pre-reset req", bus.score_req, 1);
    #2 reset = 1'b0;
    #1 check("async reset outputs", all_outs(), 0);
    step();
    reset = 1'b1;

    // IDLE ignores select and mode.
    hs0 = hs_cnt;
    btn_select = 1'b1; step(); btn_select = 1'b0;
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    check("idle select ignored", hs_cnt - hs0, 0);
    check("idle outputs", all_outs(), 0);

    press_start("start4");
    step();
    check("secret queue drained", secret_q.size(), 0);
    check("score queue drained", score_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
